regfile_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single write port of the 32x32 `register_file` between three result producers: ALU, load unit (MEM) and the multi-cycle multiply/divide unit (MDU). It grants at most one request per cycle using round-robin priority, registers the winner and drives `RegWrite`, `reg_write_addr` and `write_data` of the register file directly. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundle of the three result-producer handshakes (ALU, MEM, MDU) and the
// register-file write port driven by the write-back arbiter.
//   x_valid/x_addr/x_data : producer request (held stable until transfer)
//   x_ready               : arbiter accepts the request this cycle
//   RegWrite/reg_write_addr/write_data : register_file write port
//   wb_src                : source of the current write (0 ALU,1 MEM,2 MDU,3 none)
// Modports: slave = arbiter side, master = producers/register-file side.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;

  logic              RegWrite;
  logic [ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0] write_data;
  logic [1:0]        wb_src;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  mdu_valid, mdu_addr, mdu_data,
    output alu_ready, mem_ready, mdu_ready,
    output RegWrite, reg_write_addr, write_data, wb_src
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output mdu_valid, mdu_addr, mdu_data,
    input  alu_ready, mem_ready, mdu_ready,
    input  RegWrite, reg_write_addr, write_data, wb_src
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single write port of the 32x32 register file between the ALU,
// the load unit (MEM) and the multiply/divide unit (MDU). One request is
// granted per cycle in round-robin order; the winner is registered and drives
// the register-file write port on the following cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : regfile_wb_arbiter_if.slave (three producer handshakes + write port)
// Parameters:
//   DATA_W, ADDR_W : data / register address widths
//   DISCARD_ZERO   : accept writes to r0 but never assert RegWrite for them
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit DISCARD_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int         NSRC     = 3;
  localparam logic [1:0] SRC_NONE = 2'd3;

  logic [NSRC-1:0]   valid_vec;
  logic [NSRC-1:0]   grant_vec;
  logic              grant_any;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic [1:0]        ptr_reg;
  logic [1:0]        ptr_next;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [1:0]        src_reg;

  logic [1:0]        slot_idx [NSRC];

  assign valid_vec = {bus.mdu_valid, bus.mem_valid, bus.alu_valid};

  // Slot gi holds the source id with the gi-th highest priority this cycle:
  // (ptr + gi) mod 3. ptr never exceeds 2, so one conditional subtract suffices.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_slot
      logic [2:0] sum;
      assign sum          = {1'b0, ptr_reg} + 3'(gi);
      assign slot_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    end
  endgenerate

  // First valid source in priority order wins.
  always_comb begin
    grant_any = 1'b0;
    win_idx   = SRC_NONE;
    grant_vec = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!grant_any && valid_vec[slot_idx[i]]) begin
        grant_any = 1'b1;
        win_idx   = slot_idx[i];
      end
    end
    if (grant_any) begin
      grant_vec[win_idx] = 1'b1;
    end
  end

  always_comb begin
    win_addr = bus.alu_addr;
    win_data = bus.alu_data;
    case (win_idx)
      2'd1: begin
        win_addr = bus.mem_addr;
        win_data = bus.mem_data;
      end
      2'd2: begin
        win_addr = bus.mdu_addr;
        win_data = bus.mdu_data;
      end
      default: begin
        win_addr = bus.alu_addr;
        win_data = bus.alu_data;
      end
    endcase
  end

  assign ptr_next = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;

  // Readies are masked by reset so no transfer can be seen while rst is low.
  assign bus.alu_ready = grant_vec[0] & rst;
  assign bus.mem_ready = grant_vec[1] & rst;
  assign bus.mdu_ready = grant_vec[2] & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg  <= 2'd0;
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
      src_reg  <= SRC_NONE;
    end else if (grant_any) begin
      ptr_reg  <= ptr_next;
      addr_reg <= win_addr;
      data_reg <= win_data;
      src_reg  <= win_idx;
      // r0 writes complete the handshake but are suppressed at the port.
      we_reg   <= !(DISCARD_ZERO && (win_addr == '0));
    end else begin
      we_reg   <= 1'b0;
      src_reg  <= SRC_NONE;
    end
  end

  assign bus.RegWrite       = we_reg;
  assign bus.reg_write_addr = addr_reg;
  assign bus.write_data     = data_reg;
  assign bus.wb_src         = src_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter: a behavioural round-robin model
// checked against the DUT every cycle, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b1;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DISCARD_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_ptr  = 0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_src  = 3;

  function automatic int pick(input int p, input logic [2:0] v);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (p + i) % 3;
      if (v[k]) return k;
    end
    return 3;
  endfunction

  function automatic logic [2:0] cur_valids();
    return {bus.mdu_valid, bus.mem_valid, bus.alu_valid};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_src = 3;
    end else begin
      int w;
      logic [4:0]  a [3];
      logic [31:0] d [3];
      a[0] = bus.alu_addr; a[1] = bus.mem_addr; a[2] = bus.mdu_addr;
      d[0] = bus.alu_data; d[1] = bus.mem_data; d[2] = bus.mdu_data;
      w = pick(m_ptr, cur_valids());
      if (w < 3) begin
        m_addr = a[w];
        m_data = d[w];
        m_src  = w;
        m_we   = (a[w] != 5'd0);
        m_ptr  = (w + 1) % 3;
      end else begin
        m_we  = 1'b0;
        m_src = 3;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- per-cycle compare against model ----------------
  always @(negedge clk) begin
    if (running) begin
      logic [2:0] exp_rdy;
      int w;
      exp_rdy = 3'b000;
      if (rst) begin
        w = pick(m_ptr, cur_valids());
        if (w < 3) exp_rdy[w] = 1'b1;
      end
      check("model_ready", 32'({bus.mdu_ready, bus.mem_ready, bus.alu_ready}), 32'(exp_rdy));
      check("model_regwrite", 32'(bus.RegWrite), 32'(m_we));
      check("model_addr", 32'(bus.reg_write_addr), 32'(m_addr));
      check("model_data", bus.write_data, m_data);
      check("model_src", 32'(bus.wb_src), 32'(m_src));
      if (bus.wb_src != 2'd3)
        $display("wb src=%0d addr=%0d data=0x%08h we=%0b", bus.wb_src, bus.reg_write_addr,
                 bus.write_data, bus.RegWrite);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2);
    bus.alu_valid = v[0]; bus.alu_addr = a0; bus.alu_data = d0;
    bus.mem_valid = v[1]; bus.mem_addr = a1; bus.mem_data = d1;
    bus.mdu_valid = v[2]; bus.mdu_addr = a2; bus.mdu_data = d2;
  endtask

  task automatic idle();
    drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic [1:0] s);
    check({tag, "_regwrite"}, 32'(bus.RegWrite), 32'(we));
    check({tag, "_addr"}, 32'(bus.reg_write_addr), 32'(a));
    check({tag, "_data"}, bus.write_data, d);
    check({tag, "_src"}, 32'(bus.wb_src), 32'(s));
  endtask

  task automatic expect_rdy(input string tag, input logic [2:0] r);
    check({tag, "_ready"}, 32'({bus.mdu_ready, bus.mem_ready, bus.alu_ready}), 32'(r));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    idle();
    #1 rst = 1'b0;

    // Reset with all sources valid
    drive(3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33);
    next_cycle();
    mid();
    expect_rdy("reset", 3'b000);
    expect_out("reset", 1'b0, 5'd0, 32'd0, 2'd3);

    // Single ALU write after reset release
    next_cycle();
    drive(3'b001, 5'd3, 32'h0000_2110, 5'd0, 32'd0, 5'd0, 32'd0);
    rst = 1'b1;
    mid();
    expect_rdy("alu_single", 3'b001);
    next_cycle();
    idle();
    mid();
    expect_out("alu_single", 1'b1, 5'd3, 32'h0000_2110, 2'd0);
    next_cycle();
    mid();
    check("alu_single_after_regwrite", 32'(bus.RegWrite), 32'd0);
    check("alu_single_after_src", 32'(bus.wb_src), 32'd3);

    // All three continuously valid from reset release
    next_cycle();
    rst = 1'b0;
    drive(3'b111, 5'd1, 32'h101, 5'd2, 32'h102, 5'd3, 32'h103);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      expect_rdy("rr_rotate", 3'(1 << (k % 3)));
      if (k > 0) begin
        check("rr_regwrite", 32'(bus.RegWrite), 32'd1);
        check("rr_addr", 32'(bus.reg_write_addr), 32'((k - 1) % 3 + 1));
      end
      next_cycle();
    end
    idle();

    // Discarded write to r0 still advances the pointer
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    drive(3'b010, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0);
    mid();
    expect_rdy("zero_mem", 3'b010);
    next_cycle();
    drive(3'b101, 5'd9, 32'h99, 5'd0, 32'd0, 5'd5, 32'h55);
    mid();
    expect_out("zero_mem", 1'b0, 5'd0, 32'hFFFF_FFFF, 2'd1);
    expect_rdy("zero_next_mdu", 3'b100);
    next_cycle();
    drive(3'b001, 5'd9, 32'h99, 5'd0, 32'd0, 5'd0, 32'd0);
    mid();
    expect_out("zero_next_mdu", 1'b1, 5'd5, 32'h55, 2'd2);
    expect_rdy("zero_then_alu", 3'b001);
    next_cycle();
    idle();
    mid();
    expect_out("zero_then_alu", 1'b1, 5'd9, 32'h99, 2'd0);

    // Mid-cycle reset discards a registered MDU write
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 32'h77);
    mid();
    expect_rdy("midrst_mdu", 3'b100);
    next_cycle();
    idle();
    mid();
    expect_out("midrst_before", 1'b1, 5'd7, 32'h77, 2'd2);
    #1 rst = 1'b0;
    #1;
    expect_out("midrst_async", 1'b0, 5'd0, 32'd0, 2'd3);
    next_cycle();
    rst = 1'b1;
    drive(3'b011, 5'd10, 32'hA0, 5'd11, 32'hB0, 5'd0, 32'd0);
    mid();
    expect_rdy("midrst_alu_first", 3'b001);
    next_cycle();
    drive(3'b010, 5'd0, 32'd0, 5'd11, 32'hB0, 5'd0, 32'd0);
    mid();
    expect_rdy("midrst_mem_second", 3'b010);
    expect_out("midrst_alu_out", 1'b1, 5'd10, 32'hA0, 2'd0);
    next_cycle();
    idle();

    // ALU back-to-back, addresses 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(3'b001, 5'(i), 32'h1000 + 32'(i), 5'd0, 32'd0, 5'd0, 32'd0);
      mid();
      expect_rdy("b2b", 3'b001);
      if (i > 1) expect_out("b2b", 1'b1, 5'(i - 1), 32'h1000 + 32'(i - 1), 2'd0);
      next_cycle();
    end
    idle();
    mid();
    expect_out("b2b_last", 1'b1, 5'd8, 32'h1008, 2'd0);
    next_cycle();
    mid();
    check("b2b_end_regwrite", 32'(bus.RegWrite), 32'd0);

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
